demux4_buf: RTL and testbench
=============================

# demux4_buf

Registered 1-to-4 demultiplexer for the DLX datapath: the distributing counterpart to the 4:1 datapath mux. One N-bit input word is steered by select S1:S0 into one of four output channels, each holding one word behind a valid/ready handshake. Independent backpressure on each channel stalls the input only when the selected channel cannot accept. It sits where a single result bus fans out to four consumers, such as writeback ports or forwarding latches.

## Interface
- N, 32, data width of input and every output channel
- CW, 16, width of accepted-word counter ACNT
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  reset: one clock; synchronous and active-high
- IN  input  N  input data word
- S0  input  1  channel select LSB
- S1  input  1  channel select MSB
- IN_VALID  input  1  IN/S0/S1 carry a word this cycle
- IN_READY  output  1  combinational; word accepted when IN_VALID & IN_READY at rising edge
- Y0, Y1, Y2, Y3  output  N each  channel data, registered
- V0, V1, V2, V3  output  1 each  channel holds valid word, registered
- R0, R1, R2, R3  input  1 each  consumer ready per channel
- ACNT  output  CW  count of accepted input words, registered

## Operation
- Channel index k = {S1,S0}: 00→0, 01→1, 10→2, 11→3.
- Each channel is a one-entry buffer with data register Yk and full flag Vk.
- Channel drain: Vk & Rk at an edge clears Vk, unless the same edge reloads channel k.
- IN_READY = (S1,S0 both known 0/1) & (!Vk | Rk) for the selected k. It depends only on S0, S1, V*, R*, never on IN_VALID.
- Accept: IN_VALID & IN_READY. At the edge, Yk <= IN and Vk <= 1. Channels other than k are unaffected.
- Simultaneous drain and accept on the same channel: old word leaves, new word loaded, Vk stays 1. Pass-through at full rate, one word per cycle.
- Drains on non-selected channels proceed in parallel with an accept on channel k.
- Unaccepted or held channels: Yk holds its value; consumers must not sample Yk while Vk = 0.
- Select containing X/Z: IN_READY = 0, no load, no count. Drains still proceed.
- ACNT increments by 1 on every accept and wraps from 2^CW−1 to 0.
- RESET (any cycle, including mid-transfer): next edge sets V0..V3 = 0, Y0..Y3 = 0, ACNT = 0. An accept or drain coinciding with RESET is discarded. While RESET is high, IN_READY is evaluated from post-reset state only after the edge.

## Timing
- Latency: word accepted at edge t has Vk = 1 and Yk valid after edge t; earliest consumer take at edge t+1.
- Throughput: 1 word/cycle per channel when Rk held high. Aggregate is also 1 word/cycle, bounded by the single input.
- Stall: selected channel full with Rk = 0 gives IN_READY = 0. The producer must hold IN, S0, S1 and IN_VALID stable until accepted.
- Combinational paths: S0/S1/R*/V* → IN_READY only. Y*, V* and ACNT have no combinational input dependence.
- Reset values: Y* = 0, V* = 0, ACNT = 0. IN_READY = 1 after reset when the select is known.

## Test plan
- Reset then route: RESET 1 cycle. Send IN = 0xA5A5A5A5 with S1S0 = 10 and IN_VALID = 1, R2 = 0. Required: after the edge V2 = 1, Y2 = 0xA5A5A5A5, V0/V1/V3 = 0, ACNT = 1.
- Backpressure: V2 = 1, R2 = 0, select 10, IN_VALID = 1 with IN = 0x11. Required: IN_READY = 0 and Y2 unchanged for 5 cycles. Raise R2: same edge drains and loads 0x11, V2 stays 1, ACNT += 1.
- Full-rate pass-through: R1 = 1, select 01, stream 0..9 on consecutive cycles. Required: IN_READY = 1 throughout, Y1 shows 0..9 one cycle later each, and V1 drops the cycle after the last word.
- Parallel drain: V0 = V3 = 1. Accept to channel 1 while R0 = R3 = 1. Required: V0 = V3 = 0 and V1 = 1 after the edge, with Y3 value unchanged.
- Wrap and X-select: with CW = 4, accept 17 words and require ACNT = 1. Drive S0 = X with IN_VALID = 1 and require IN_READY = 0, no V change, ACNT unchanged.
- Reset mid-operation: all four channels full and an accept in flight. Assert RESET. Required: after the edge V* = 0, Y* = 0, ACNT = 0, and the in-flight word is lost.

Source files
------------

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer: one input word steered by {S1,S0} into one of
// four single-entry valid/ready output buffers, with an accepted-word counter.
module demux4_buf #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [N-1:0]  IN,
    input  logic          S0,
    input  logic          S1,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [N-1:0]  Y0,
    output logic [N-1:0]  Y1,
    output logic [N-1:0]  Y2,
    output logic [N-1:0]  Y3,
    output logic          V0,
    output logic          V1,
    output logic          V2,
    output logic          V3,
    input  logic          R0,
    input  logic          R1,
    input  logic          R2,
    input  logic          R3,
    output logic [CW-1:0] ACNT
);

    logic [N-1:0]  y_q [4];
    logic [N-1:0]  y_d [4];
    logic [3:0]    v_q, v_d;
    logic [CW-1:0] acnt_q, acnt_d;
    logic [3:0]    rdy;
    logic [1:0]    sel;
    logic          sel_known;
    logic          accept;

    assign rdy = {R3, R2, R1, R0};
    assign sel = {S1, S0};

    // An X/Z select must never load a channel; synthesis sees this as constant 1.
    assign sel_known = ((^sel) !== 1'bx);

    always_comb begin
        IN_READY = 1'b0;
        if (sel_known) begin
            IN_READY = !v_q[sel] || rdy[sel];
        end
    end

    assign accept = IN_VALID && IN_READY;

    // Drains happen on every channel; an accept then overrides its own channel.
    always_comb begin
        v_d    = v_q & ~rdy;
        y_d    = y_q;
        acnt_d = acnt_q;
        if (accept) begin
            v_d[sel] = 1'b1;
            y_d[sel] = IN;
            acnt_d   = acnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v_q    <= '0;
            acnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            acnt_q <= acnt_d;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= y_d[i];
            end
        end
    end

    assign Y0   = y_q[0];
    assign Y1   = y_q[1];
    assign Y2   = y_q[2];
    assign Y3   = y_q[3];
    assign V0   = v_q[0];
    assign V1   = v_q[1];
    assign V2   = v_q[2];
    assign V3   = v_q[3];
    assign ACNT = acnt_q;

endmodule

// File: tb/tb_demux4_buf.sv
// Self-checking bench for demux4_buf: directed scenarios plus a randomized run
// against a per-edge behavioural model of the four channel buffers.
module tb_demux4_buf;

    localparam int unsigned N  = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  din;
    logic          s0, s1, vld;
    logic [3:0]    r;
    logic          in_ready;
    logic [N-1:0]  y0, y1, y2, y3;
    logic          v0, v1, v2, v3;
    logic [CW-1:0] acnt;

    logic [N-1:0]  y_o [4];
    logic [3:0]    v_o;

    // Reference model state
    logic [N-1:0]  m_y [4];
    logic [3:0]    m_v;
    int unsigned   m_cnt;

    int n_vec;
    int n_err;

    demux4_buf #(.N(N), .CW(CW)) dut (
        .CLK     (clk),
        .RESET   (rst),
        .IN      (din),
        .S0      (s0),
        .S1      (s1),
        .IN_VALID(vld),
        .IN_READY(in_ready),
        .Y0      (y0),
        .Y1      (y1),
        .Y2      (y2),
        .Y3      (y3),
        .V0      (v0),
        .V1      (v1),
        .V2      (v2),
        .V3      (v3),
        .R0      (r[0]),
        .R1      (r[1]),
        .R2      (r[2]),
        .R3      (r[3]),
        .ACNT    (acnt)
    );

    assign y_o[0] = y0;
    assign y_o[1] = y1;
    assign y_o[2] = y2;
    assign y_o[3] = y3;
    assign v_o    = {v3, v2, v1, v0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_ready();
        logic [1:0] k;
        k = {s1, s0};
        if ($isunknown(k)) return 1'b0;
        return !m_v[k] || r[k];
    endfunction

    task automatic model_edge();
        logic [1:0] k;
        logic       acc;
        k   = {s1, s0};
        acc = vld && model_ready();
        if (rst) begin
            m_v   = '0;
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_y[i] = '0;
        end else begin
            m_v = m_v & ~r;
            if (acc) begin
                m_y[k] = din;
                m_v[k] = 1'b1;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end
        end
    endtask

    task automatic clock();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] k, input logic [N-1:0] d, input logic v);
        {s1, s0} = k;
        din      = d;
        vld      = v;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(2'b00, '0, 1'b0);
        r = '0;
        clock();
        rst = 1'b0;
        #1;
        n_vec++;
        if (v_o !== 4'b0000) begin
            n_err++; $display("FAIL reset_v: got %b expected 0000", v_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (y_o[i] !== '0) begin
                n_err++; $display("FAIL reset_y%0d: got %h expected 0", i, y_o[i]);
            end
        end
        n_vec++;
        if (acnt !== '0) begin
            n_err++; $display("FAIL reset_acnt: got %0d expected 0", acnt);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_route();
        r = '0;
        set_in(2'b10, 32'hA5A5A5A5, 1'b1);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL route_ready: got %b expected 1", in_ready);
        end
        clock();
        n_vec++;
        if (v_o !== 4'b0100) begin
            n_err++; $display("FAIL route_v: got %b expected 0100", v_o);
        end
        n_vec++;
        if (y2 !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL route_y2: got %h expected a5a5a5a5", y2);
        end
        n_vec++;
        if (acnt !== CW'(1)) begin
            n_err++; $display("FAIL route_acnt: got %0d expected 1", acnt);
        end
    endtask

    task automatic test_backpressure();
        int unsigned cnt0;
        cnt0 = m_cnt;
        r = '0;
        set_in(2'b10, 32'h11, 1'b1);
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_ready c%0d: got %b expected 0", c, in_ready);
            end
            clock();
            n_vec++;
            if (y2 !== 32'hA5A5A5A5 || v2 !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold c%0d: got y2=%h v2=%b expected a5a5a5a5/1", c, y2, v2);
            end
        end
        r[2] = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL release_ready: got %b expected 1", in_ready);
        end
        clock();
        n_vec++;
        if (y2 !== 32'h11 || v2 !== 1'b1) begin
            n_err++; $display("FAIL release_load: got y2=%h v2=%b expected 11/1", y2, v2);
        end
        n_vec++;
        if (acnt !== CW'((cnt0 + 1) % 16)) begin
            n_err++; $display("FAIL release_acnt: got %0d expected %0d", acnt, (cnt0 + 1) % 16);
        end
        set_in(2'b10, '0, 1'b0);
        clock();
        r = '0;
    endtask

    task automatic test_pass_through();
        r = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            set_in(2'b01, N'(i), 1'b1);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL pass_ready w%0d: got %b expected 1", i, in_ready);
            end
            clock();
            n_vec++;
            if (y1 !== N'(i) || v1 !== 1'b1) begin
                n_err++;
                $display("FAIL pass_y1 w%0d: got y1=%0d v1=%b expected %0d/1", i, y1, v1, i);
            end
        end
        set_in(2'b01, '0, 1'b0);
        clock();
        n_vec++;
        if (v1 !== 1'b0) begin
            n_err++; $display("FAIL pass_drop_v1: got %b expected 0", v1);
        end
        r = '0;
    endtask

    task automatic test_parallel_drain();
        logic [N-1:0] y3val;
        y3val = $urandom;
        r = '0;
        set_in(2'b00, $urandom, 1'b1);
        clock();
        set_in(2'b11, y3val, 1'b1);
        clock();
        r = 4'b1001;
        set_in(2'b01, $urandom, 1'b1);
        clock();
        n_vec++;
        if (v_o !== 4'b0010) begin
            n_err++; $display("FAIL par_v: got %b expected 0010", v_o);
        end
        n_vec++;
        if (y3 !== y3val) begin
            n_err++; $display("FAIL par_y3: got %h expected %h", y3, y3val);
        end
        set_in(2'b00, '0, 1'b0);
        r = 4'b1111;
        clock();
        r = '0;
    endtask

    task automatic test_wrap_xsel();
        logic [3:0] v_before;
        logic [CW-1:0] c_before;
        rst = 1'b1;
        clock();
        rst = 1'b0;
        r = 4'b0001;
        for (int i = 0; i < 17; i++) begin
            set_in(2'b00, $urandom, 1'b1);
            clock();
        end
        n_vec++;
        if (acnt !== CW'(1)) begin
            n_err++; $display("FAIL wrap_acnt: got %0d expected 1", acnt);
        end
        r = '0;
        v_before = v_o;
        c_before = acnt;
        s1  = 1'b0;
        s0  = 1'bx;
        vld = 1'b1;
        #1;
        if ($isunknown(s0)) begin
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL xsel_ready: got %b expected 0", in_ready);
            end
            clock();
            n_vec++;
            if (v_o !== v_before || acnt !== c_before) begin
                n_err++;
                $display("FAIL xsel_hold: got v=%b acnt=%0d expected %b/%0d",
                         v_o, acnt, v_before, c_before);
            end
        end
        set_in(2'b00, '0, 1'b0);
    endtask

    task automatic test_reset_mid();
        r = '0;
        for (int k = 0; k < 4; k++) begin
            set_in(2'(k), $urandom | 32'h1, 1'b1);
            clock();
        end
        r = 4'b0010;
        set_in(2'b01, 32'hDEADBEEF, 1'b1);
        rst = 1'b1;
        clock();
        rst = 1'b0;
        set_in(2'b00, '0, 1'b0);
        r = '0;
        n_vec++;
        if (v_o !== 4'b0000) begin
            n_err++; $display("FAIL midrst_v: got %b expected 0000", v_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (y_o[i] !== '0) begin
                n_err++; $display("FAIL midrst_y%0d: got %h expected 0", i, y_o[i]);
            end
        end
        n_vec++;
        if (acnt !== '0) begin
            n_err++; $display("FAIL midrst_acnt: got %0d expected 0", acnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            r   = 4'($urandom);
            set_in(2'($urandom), $urandom, 1'($urandom));
            n_vec++;
            if (in_ready !== model_ready()) begin
                n_err++;
                $display("FAIL rand_ready c%0d: got %b expected %b", c, in_ready, model_ready());
            end
            clock();
            n_vec++;
            if (v_o !== m_v || acnt !== CW'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_state c%0d: got v=%b acnt=%0d expected %b/%0d",
                         c, v_o, acnt, m_v, m_cnt);
            end
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (y_o[i] !== m_y[i]) begin
                    n_err++;
                    $display("FAIL rand_y%0d c%0d: got %h expected %h", i, c, y_o[i], m_y[i]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_v   = '0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_y[i] = '0;
        rst = 1'b1;
        din = '0;
        s0  = 1'b0;
        s1  = 1'b0;
        vld = 1'b0;
        r   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_route();
        test_backpressure();
        test_pass_through();
        test_parallel_drain();
        test_wrap_xsel();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
